mmio_io_hub: RTL and testbench

- Parametrised memory-mapped IO hub between the OTTER_MCU IOBUS and board peripherals.
- Replaces hand-coded per-address case decode with three generated register banks:
  - NUM_OUT output registers, each with a one-cycle write strobe.
  - NUM_IN synchronised input ports.
  - An interrupt controller with edge detection, pending/mask registers and a single INTR line to the MCU.
- Output registers can be read back.

---
 rtl/mmio_io_hub_if.sv | 23 ++
 rtl/mmio_io_hub.sv | 232 +++++++++++++++++++++++
 tb/tb_mmio_io_hub.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_io_hub_if.sv
// MCU IO bus bundle for the OTTER_MCU IOBUS side of the IO hub.
// The master drives address, write data and write enable; the slave returns
// combinational read data.
interface mmio_io_hub_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  IOBUS_IN
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output IOBUS_IN
    );
endinterface

// File: rtl/mmio_io_hub.sv
// Memory-mapped IO hub between the OTTER_MCU IOBUS and board peripherals.
// Three banks are decoded by exact address match at BASE + k*STRIDE:
//   - NUM_OUT output registers, each with a one-cycle write strobe
//   - NUM_IN input ports behind 2-flop synchronisers
//   - interrupt controller: IRQ_PEND (write-1-to-clear) and IRQ_MASK
// Reads are combinational and side-effect free; unmapped addresses read 0.
module mmio_io_hub #(
    parameter int          NUM_OUT   = 4,
    parameter int          NUM_IN    = 4,
    parameter int          NUM_IRQ   = 2,
    parameter int          DW        = 16,
    parameter logic [31:0] IN_BASE   = 32'h1100_0000,
    parameter logic [31:0] OUT_BASE  = 32'h1120_0000,
    parameter logic [31:0] CTRL_BASE = 32'h1140_0000,
    parameter logic [31:0] STRIDE    = 32'h0004_0000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    mmio_io_hub_if.slave            iobus,
    input  logic [NUM_IN*DW-1:0]    IN_DATA,
    output logic [NUM_OUT*DW-1:0]   OUT_DATA,
    output logic [NUM_OUT-1:0]      OUT_STB,
    input  logic [NUM_IRQ-1:0]      IRQ_SRC,
    output logic                    INTR
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------

    // Closed address interval [base, base + (n-1)*STRIDE], computed in 64 bits
    // so a bank running past the top of the 32-bit space is still caught.
    function automatic logic [63:0] bank_hi(input logic [31:0] base, input int n);
        return {32'h0, base} + (64'(n) - 64'd1) * {32'h0, STRIDE};
    endfunction

    function automatic bit banks_overlap(input logic [31:0] a_base, input int a_n,
                                         input logic [31:0] b_base, input int b_n);
        return ({32'h0, a_base} <= bank_hi(b_base, b_n)) &&
               ({32'h0, b_base} <= bank_hi(a_base, a_n));
    endfunction

    localparam bit ADDR_CLASH =
        banks_overlap(IN_BASE,  NUM_IN,  OUT_BASE,  NUM_OUT) ||
        banks_overlap(IN_BASE,  NUM_IN,  CTRL_BASE, 2)       ||
        banks_overlap(OUT_BASE, NUM_OUT, CTRL_BASE, 2)       ||
        (bank_hi(IN_BASE,   NUM_IN)  > 64'hFFFF_FFFF)        ||
        (bank_hi(OUT_BASE,  NUM_OUT) > 64'hFFFF_FFFF)        ||
        (bank_hi(CTRL_BASE, 2)       > 64'hFFFF_FFFF);

    localparam bit PARAM_RANGE_BAD =
        (NUM_OUT < 1) || (NUM_OUT > 16) ||
        (NUM_IN  < 1) || (NUM_IN  > 16) ||
        (NUM_IRQ < 1) || (NUM_IRQ > 32) ||
        (DW      < 1) || (DW      > 32) ||
        (STRIDE == 32'h0);

    generate
        if (ADDR_CLASH) begin : g_addr_clash
            $fatal(1, "mmio_io_hub: IN/OUT/CTRL address ranges overlap");
        end
        if (PARAM_RANGE_BAD) begin : g_param_range
            $fatal(1, "mmio_io_hub: parameter out of supported range");
        end
    endgenerate

    localparam logic [31:0] PEND_ADDR = CTRL_BASE;
    localparam logic [31:0] MASK_ADDR = CTRL_BASE + STRIDE;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_OUT-1:0][DW-1:0] out_q,      out_d;
    logic [NUM_OUT-1:0]         out_stb_q,  out_stb_d;
    logic [NUM_IN*DW-1:0]       in_s1_q,    in_s1_d;
    logic [NUM_IN*DW-1:0]       in_s2_q,    in_s2_d;
    logic [NUM_IRQ-1:0]         irq_s1_q,   irq_s1_d;
    logic [NUM_IRQ-1:0]         irq_s2_q,   irq_s2_d;
    logic [NUM_IRQ-1:0]         irq_dly_q,  irq_dly_d;
    logic [NUM_IRQ-1:0]         pend_q,     pend_d;
    logic [NUM_IRQ-1:0]         mask_q,     mask_d;
    logic                       intr_q,     intr_d;

    // Decode results
    logic [NUM_OUT-1:0] out_hit;
    logic [NUM_IN-1:0]  in_hit;
    logic               pend_hit;
    logic               mask_hit;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [31:0]        rdata;

    // Only the low DW / NUM_IRQ bits of the write data are meaningful.
    logic unused_wdata;
    assign unused_wdata = ^iobus.IOBUS_OUT;

    // ------------------------------------------------------------------
    // Address decode: exact match against every bank slot
    // ------------------------------------------------------------------

    // Compare the bus address against each generated register address.
    always_comb begin
        out_hit  = '0;
        in_hit   = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_hit[k] = (iobus.IOBUS_ADDR == OUT_BASE + 32'(k) * STRIDE);
        end
        for (int k = 0; k < NUM_IN; k++) begin
            in_hit[k] = (iobus.IOBUS_ADDR == IN_BASE + 32'(k) * STRIDE);
        end
        pend_hit = (iobus.IOBUS_ADDR == PEND_ADDR);
        mask_hit = (iobus.IOBUS_ADDR == MASK_ADDR);
    end

    // ------------------------------------------------------------------
    // Output registers and strobes
    // ------------------------------------------------------------------

    // Load the addressed output register and raise its strobe for one cycle.
    always_comb begin
        out_d     = out_q;
        out_stb_d = '0;
        if (iobus.IOBUS_WR) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (out_hit[k]) begin
                    out_d[k]     = iobus.IOBUS_OUT[DW-1:0];
                    out_stb_d[k] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------

    // Two-flop synchroniser on every raw input bit.
    always_comb begin
        in_s1_d = IN_DATA;
        in_s2_d = in_s1_q;
    end

    // ------------------------------------------------------------------
    // Interrupt controller
    // ------------------------------------------------------------------

    // Rising-edge detect on the synchronised sources.
    assign irq_rise = irq_s2_q & ~irq_dly_q;

    // Synchronise sources, update pending (set beats W1C), mask and INTR.
    always_comb begin
        irq_s1_d  = IRQ_SRC;
        irq_s2_d  = irq_s1_q;
        irq_dly_d = irq_s2_q;

        pend_clr = '0;
        mask_d   = mask_q;
        if (iobus.IOBUS_WR && pend_hit) begin
            pend_clr = iobus.IOBUS_OUT[NUM_IRQ-1:0];
        end
        if (iobus.IOBUS_WR && mask_hit) begin
            mask_d = iobus.IOBUS_OUT[NUM_IRQ-1:0];
        end

        pend_d = (pend_q & ~pend_clr) | irq_rise;
        intr_d = |(pend_q & mask_q);
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------

    // Zero-extended combinational read of whichever register is addressed.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (out_hit[k]) begin
                rdata[DW-1:0] = out_q[k];
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_hit[k]) begin
                rdata[DW-1:0] = in_s2_q[k*DW +: DW];
            end
        end
        if (pend_hit) begin
            rdata[NUM_IRQ-1:0] = pend_q;
        end
        if (mask_hit) begin
            rdata[NUM_IRQ-1:0] = mask_q;
        end
    end

    assign iobus.IOBUS_IN = rdata;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // All hub state clears asynchronously on RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_q     <= '0;
            out_stb_q <= '0;
            in_s1_q   <= '0;
            in_s2_q   <= '0;
            irq_s1_q  <= '0;
            irq_s2_q  <= '0;
            irq_dly_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            intr_q    <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_stb_q <= out_stb_d;
            in_s1_q   <= in_s1_d;
            in_s2_q   <= in_s2_d;
            irq_s1_q  <= irq_s1_d;
            irq_s2_q  <= irq_s2_d;
            irq_dly_q <= irq_dly_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            intr_q    <= intr_d;
        end
    end

    assign OUT_DATA = out_q;
    assign OUT_STB  = out_stb_q;
    assign INTR     = intr_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed + randomized bench for mmio_io_hub. The reference model tracks the
// hub in terms of its visible behaviour: register contents, pin history
// queues (inputs visible 2 edges late, IRQ edges pending 3 edges late) and a
// registered INTR derived from last cycle's pending/mask.
module tb_mmio_io_hub;
    localparam int          NUM_OUT   = 4;
    localparam int          NUM_IN    = 4;
    localparam int          NUM_IRQ   = 2;
    localparam int          DW        = 16;
    localparam logic [31:0] IN_BASE   = 32'h1100_0000;
    localparam logic [31:0] OUT_BASE  = 32'h1120_0000;
    localparam logic [31:0] CTRL_BASE = 32'h1140_0000;
    localparam logic [31:0] STRIDE    = 32'h0004_0000;
    localparam logic [31:0] PEND_A    = CTRL_BASE;
    localparam logic [31:0] MASK_A    = CTRL_BASE + STRIDE;

    logic                  CLK = 1'b0;
    logic                  RESET = 1'b1;
    logic [NUM_IN*DW-1:0]  IN_DATA = '0;
    logic [NUM_OUT*DW-1:0] OUT_DATA;
    logic [NUM_OUT-1:0]    OUT_STB;
    logic [NUM_IRQ-1:0]    IRQ_SRC = '0;
    logic                  INTR;

    mmio_io_hub_if iobus ();

    mmio_io_hub #(
        .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .NUM_IRQ(NUM_IRQ), .DW(DW),
        .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .CTRL_BASE(CTRL_BASE), .STRIDE(STRIDE)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .iobus(iobus.slave),
        .IN_DATA(IN_DATA),
        .OUT_DATA(OUT_DATA),
        .OUT_STB(OUT_STB),
        .IRQ_SRC(IRQ_SRC),
        .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0]         m_out [NUM_OUT];
    logic [NUM_OUT-1:0]    m_stb;
    logic [NUM_IRQ-1:0]    m_pend, m_mask, m_rise, m_clr;
    logic                  m_intr;
    logic [NUM_IN*DW-1:0]  in_hist [$];
    logic [NUM_IRQ-1:0]    irq_hist [$];
    int                    m_n;

    task automatic m_clear();
        for (int i = 0; i < NUM_OUT; i++) m_out[i] = '0;
        m_stb  = '0;
        m_pend = '0;
        m_mask = '0;
        m_intr = 1'b0;
        in_hist.delete();
        irq_hist.delete();
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_clear();
        end else begin
            in_hist.push_back(IN_DATA);
            irq_hist.push_back(IRQ_SRC);
            m_n    = irq_hist.size();
            m_rise = '0;
            if (m_n >= 3) begin
                m_rise = irq_hist[m_n-3];
                if (m_n >= 4) m_rise = m_rise & ~irq_hist[m_n-4];
            end
            m_intr = |(m_pend & m_mask);
            m_clr  = '0;
            m_stb  = '0;
            if (iobus.IOBUS_WR) begin
                if (iobus.IOBUS_ADDR == PEND_A) m_clr  = iobus.IOBUS_OUT[NUM_IRQ-1:0];
                if (iobus.IOBUS_ADDR == MASK_A) m_mask = iobus.IOBUS_OUT[NUM_IRQ-1:0];
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (iobus.IOBUS_ADDR == OUT_BASE + 32'(i) * STRIDE) begin
                        m_out[i] = iobus.IOBUS_OUT[DW-1:0];
                        m_stb[i] = 1'b1;
                    end
                end
            end
            m_pend = (m_pend & ~m_clr) | m_rise;
        end
    end

    function automatic logic [NUM_OUT*DW-1:0] m_out_packed();
        logic [NUM_OUT*DW-1:0] r;
        for (int i = 0; i < NUM_OUT; i++) r[i*DW +: DW] = m_out[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0]          r;
        logic [NUM_IN*DW-1:0] v;
        int                   n;
        r = '0;
        n = in_hist.size();
        v = (n >= 2) ? in_hist[n-2] : '0;
        for (int i = 0; i < NUM_OUT; i++)
            if (a == OUT_BASE + 32'(i) * STRIDE) r[DW-1:0] = m_out[i];
        for (int j = 0; j < NUM_IN; j++)
            if (a == IN_BASE + 32'(j) * STRIDE) r[DW-1:0] = v[j*DW +: DW];
        if (a == PEND_A) r[NUM_IRQ-1:0] = m_pend;
        if (a == MASK_A) r[NUM_IRQ-1:0] = m_mask;
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_out"},  64'(OUT_DATA), 64'(m_out_packed()));
        chk({tag, "_stb"},  64'(OUT_STB),  64'(m_stb));
        chk({tag, "_intr"}, 64'(INTR),     64'(m_intr));
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        iobus.IOBUS_ADDR = a;
        iobus.IOBUS_WR   = 1'b0;
        #1;
        chk(tag, 64'(iobus.IOBUS_IN), 64'(exp_read(a)));
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        iobus.IOBUS_ADDR = a;
        iobus.IOBUS_OUT  = d;
        iobus.IOBUS_WR   = 1'b1;
        cyc();
        iobus.IOBUS_WR   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        logic [31:0] a;
        m_clear();
        iobus.IOBUS_ADDR = '0;
        iobus.IOBUS_OUT  = '0;
        iobus.IOBUS_WR   = 1'b0;
        RESET = 1'b1;
        repeat (3) cyc();

        // write presented during reset is lost
        wr(OUT_BASE, 32'h0000_FFFF);
        RESET = 1'b0;
        chk_state("rst");
        chk("rst_out_zero", 64'(OUT_DATA), 64'h0);
        rd("rst_pend", PEND_A);
        rd("rst_mask", MASK_A);
        rd("rst_out0", OUT_BASE);

        // plan write to register 1
        wr(OUT_BASE + STRIDE, 32'hABCD_1234);
        chk("w1_data", 64'(OUT_DATA[1*DW +: DW]), 64'h1234);
        chk("w1_stb", 64'(OUT_STB), 64'b0010);
        chk_state("w1");
        cyc();
        chk("w1_stb_off", 64'(OUT_STB), 64'h0);
        rd("w1_rd", OUT_BASE + STRIDE);
        chk("w1_rd_const", 64'(iobus.IOBUS_IN), 64'h0000_1234);

        // back-to-back writes to the same register
        iobus.IOBUS_ADDR = OUT_BASE + 3 * STRIDE;
        iobus.IOBUS_OUT  = $urandom;
        iobus.IOBUS_WR   = 1'b1;
        cyc();
        chk_state("b2b_0");
        iobus.IOBUS_OUT  = $urandom;
        cyc();
        chk_state("b2b_1");
        chk("b2b_stb", 64'(OUT_STB), 64'b1000);
        iobus.IOBUS_WR   = 1'b0;
        cyc();
        chk_state("b2b_2");

        // random writes, including unmapped and input-port addresses
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: a = OUT_BASE + 32'(r) * STRIDE;
                4:          a = OUT_BASE + 32'(NUM_OUT) * STRIDE;
                5:          a = OUT_BASE + 32'h4;
                6:          a = IN_BASE + 32'($urandom_range(0, NUM_IN-1)) * STRIDE;
                7:          a = 32'h11FC_0000;
                default:    a = $urandom;
            endcase
            iobus.IOBUS_ADDR = a;
            iobus.IOBUS_OUT  = $urandom;
            iobus.IOBUS_WR   = (r != 9);
            cyc();
            iobus.IOBUS_WR   = 1'b0;
            chk_state("rw");
            rd("rw_rd", OUT_BASE + 32'($urandom_range(0, NUM_OUT-1)) * STRIDE);
        end

        // input synchroniser latency
        IN_DATA = '0;
        repeat (3) cyc();
        IN_DATA[2*DW +: DW] = 16'h00F0;
        rd("in_e0", IN_BASE + 2 * STRIDE);
        chk("in_e0_const", 64'(iobus.IOBUS_IN), 64'h0);
        cyc();
        rd("in_e1", IN_BASE + 2 * STRIDE);
        chk("in_e1_const", 64'(iobus.IOBUS_IN), 64'h0);
        cyc();
        rd("in_e2", IN_BASE + 2 * STRIDE);
        chk("in_e2_const", 64'(iobus.IOBUS_IN), 64'h0000_00F0);
        cyc();
        rd("in_e3", IN_BASE + 2 * STRIDE);
        rd("unmapped", 32'h11FC_0000);
        chk("unmapped_const", 64'(iobus.IOBUS_IN), 64'h0);
        for (int it = 0; it < 30; it++) begin
            IN_DATA = {$urandom, $urandom};
            cyc();
            rd("in_rnd_a", IN_BASE + 32'($urandom_range(0, NUM_IN-1)) * STRIDE);
            rd("in_rnd_b", IN_BASE + 32'($urandom_range(0, NUM_IN-1)) * STRIDE);
        end

        // masked-in interrupt, 3-cycle pulse on source 0
        IRQ_SRC = '0;
        wr(MASK_A, 32'h1);
        chk_state("irq_mask");
        rd("irq_mask_rd", MASK_A);
        chk("irq_mask_const", 64'(iobus.IOBUS_IN), 64'h1);
        IRQ_SRC[0] = 1'b1;
        cyc();
        rd("irq_e1", PEND_A);
        chk_state("irq_e1");
        cyc();
        rd("irq_e2", PEND_A);
        chk_state("irq_e2");
        cyc();
        IRQ_SRC[0] = 1'b0;
        rd("irq_e3", PEND_A);
        chk("irq_e3_pend", 64'(iobus.IOBUS_IN), 64'b01);
        chk("irq_e3_intr", 64'(INTR), 64'h0);
        cyc();
        chk("irq_e4_intr", 64'(INTR), 64'h1);
        chk_state("irq_e4");
        wr(PEND_A, 32'h1);
        rd("irq_w1c", PEND_A);
        chk("irq_w1c_const", 64'(iobus.IOBUS_IN), 64'h0);
        chk_state("irq_w1c");
        cyc();
        chk("irq_w1c_intr", 64'(INTR), 64'h0);
        chk_state("irq_w1c2");

        // masked-out interrupt on source 1, then unmask
        wr(MASK_A, 32'h0);
        IRQ_SRC[1] = 1'b1;
        repeat (3) cyc();
        IRQ_SRC[1] = 1'b0;
        repeat (3) begin
            cyc();
            chk_state("msk_wait");
        end
        rd("msk_pend", PEND_A);
        chk("msk_pend_const", 64'(iobus.IOBUS_IN), 64'b10);
        chk("msk_intr_low", 64'(INTR), 64'h0);
        wr(MASK_A, 32'h2);
        chk_state("unmask_e0");
        cyc();
        chk("unmask_intr", 64'(INTR), 64'h1);

        // new edge coinciding with a W1C of the same bit: set wins
        wr(PEND_A, 32'h3);
        cyc();
        IRQ_SRC[0] = 1'b1;
        repeat (2) cyc();
        IRQ_SRC[0] = 1'b0;
        repeat (4) cyc();
        rd("coin_pre", PEND_A);
        chk("coin_pre_const", 64'(iobus.IOBUS_IN), 64'b01);
        IRQ_SRC[0] = 1'b1;
        cyc();
        cyc();
        wr(PEND_A, 32'h1);
        rd("coin_post", PEND_A);
        chk("coin_post_const", 64'(iobus.IOBUS_IN), 64'b01);
        IRQ_SRC[0] = 1'b0;
        repeat (2) cyc();

        // random interrupt traffic
        for (int it = 0; it < 60; it++) begin
            IRQ_SRC = NUM_IRQ'($urandom);
            r = int'($urandom_range(0, 5));
            iobus.IOBUS_OUT = $urandom;
            iobus.IOBUS_ADDR = (r == 0) ? PEND_A : MASK_A;
            iobus.IOBUS_WR   = (r <= 1);
            cyc();
            iobus.IOBUS_WR   = 1'b0;
            chk_state("irq_rnd");
            rd("irq_rnd_pend", PEND_A);
            rd("irq_rnd_mask", MASK_A);
        end

        // mid-stream reset with an output write active
        wr(MASK_A, 32'h3);
        IRQ_SRC = '1;
        repeat (5) cyc();
        IRQ_SRC = '0;
        wr(OUT_BASE, 32'h0000_BEEF);
        iobus.IOBUS_ADDR = OUT_BASE + 2 * STRIDE;
        iobus.IOBUS_OUT  = 32'h0000_7777;
        iobus.IOBUS_WR   = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        chk_state("mid_rst");
        chk("mid_rst_out", 64'(OUT_DATA), 64'h0);
        chk("mid_rst_stb", 64'(OUT_STB), 64'h0);
        chk("mid_rst_intr", 64'(INTR), 64'h0);
        rd("mid_rst_pend", PEND_A);
        chk("mid_rst_pend_const", 64'(iobus.IOBUS_IN), 64'h0);
        iobus.IOBUS_ADDR = OUT_BASE + 2 * STRIDE;
        iobus.IOBUS_WR   = 1'b1;
        cyc();
        iobus.IOBUS_WR   = 1'b0;
        RESET = 1'b0;
        chk("post_rst_out", 64'(OUT_DATA), 64'h0);
        rd("post_rst_mask", MASK_A);
        wr(OUT_BASE + 2 * STRIDE, 32'h0000_5A5A);
        chk("post_rst_wr", 64'(OUT_DATA[2*DW +: DW]), 64'h5A5A);
        chk("post_rst_stb", 64'(OUT_STB), 64'b0100);
        chk_state("post_rst");
        cyc();
        chk_state("post_rst2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
